// File: rtl/vga_bus_pkg.sv
// Shared VGA bus definitions: responder FSM encoding and framebuffer geometry.
package vga_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADDR  = 2'd1,
      ST_WAIT  = 2'd2,
      ST_BURST = 2'd3
   } state_t;

   localparam int          RES_X     = 320;
   localparam int          RES_Y     = 240;
   localparam int          BURST_LEN = 8;
   localparam logic [31:0] FB_BASE   = 32'h0000_1050;
   // two 8-bit pixels per 16-bit word
   localparam int          FB_WORDS  = RES_X * RES_Y / 2;

endpackage

// File: rtl/count_reg.sv
// Generic up-counter with synchronous clear and count enable.
module count_reg #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset)
         q <= '0;
      else if (clr)
         q <= '0;
      else if (en)
         q <= q + W'(1);
   end

endmodule

// File: rtl/fb_burst_responder.sv
// Burst-read target for the VGA bus: acks a request, holds wait while prefetching,
// then streams BURST_LEN framebuffer words one per cycle with per-beat range checking.
module fb_burst_responder #(
   parameter int                DATA_W      = 16,
   parameter int                ADDR_W      = 32,
   parameter int                MEM_AW      = 16,
   parameter int                BURST_LEN   = vga_bus_pkg::BURST_LEN,
   parameter int                WAIT_CYCLES = 2,
   parameter logic [ADDR_W-1:0] FB_BASE     = ADDR_W'(vga_bus_pkg::FB_BASE),
   parameter int                FB_WORDS    = vga_bus_pkg::FB_WORDS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bus_req,
   input  logic [ADDR_W-1:0] bus_addr,
   output logic              bus_ack,
   output logic              bus_wait,
   output logic [DATA_W-1:0] bus_data,
   output logic              bus_dvalid,
   output logic              mem_rd_en,
   output logic [MEM_AW-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              range_err
);

   import vga_bus_pkg::*;

   localparam int                CNT_MAX   = (WAIT_CYCLES > BURST_LEN) ? WAIT_CYCLES : BURST_LEN;
   localparam int                CNT_W     = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(WAIT_CYCLES);
   localparam logic [CNT_W-1:0]  BEAT_LAST = CNT_W'(BURST_LEN - 1);
   localparam logic [ADDR_W-1:0] FB_END    = ADDR_W'(FB_WORDS);

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic                cnt_clr, cnt_en;
   logic [ADDR_W-1:0]   addr_reg;
   logic [ADDR_W-1:0]   beat_off, rd_off;
   logic                beat_ok, rd_ok;
   logic                wait_done, beat_last, rd_phase;

   // One counter serves both the wait phase and the beat phase.
   count_reg #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .q     (cnt)
   );

   assign wait_done = (state == ST_WAIT) && (cnt == WAIT_LAST);
   assign beat_last = (cnt == BEAT_LAST);
   assign cnt_clr   = (state == ST_ADDR) || wait_done;
   assign cnt_en    = (state == ST_WAIT) || (state == ST_BURST);

   // The read issued in a cycle is for the beat after the one currently on the bus.
   assign beat_off = addr_reg + ADDR_W'(cnt);
   assign rd_off   = (state == ST_BURST) ? beat_off + ADDR_W'(1) : addr_reg;
   assign beat_ok  = beat_off < FB_END;
   assign rd_ok    = rd_off < FB_END;

   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (bus_req) state_nxt = ST_ADDR;
         ST_ADDR:  state_nxt = bus_req ? ST_WAIT : ST_IDLE;
         ST_WAIT:  if (!bus_req) state_nxt = ST_IDLE;
                   else if (wait_done) state_nxt = ST_BURST;
         ST_BURST: if (!bus_req || beat_last) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus_ack    = 1'b0;
      bus_wait   = 1'b0;
      bus_dvalid = 1'b0;
      bus_data   = '0;
      rd_phase   = 1'b0;
      case (state)
         ST_IDLE:  bus_ack = bus_req & ~reset;
         ST_ADDR:  bus_wait = 1'b1;
         ST_WAIT: begin
            bus_wait = ~wait_done;
            rd_phase = wait_done & bus_req;
         end
         ST_BURST: begin
            bus_dvalid = bus_req;
            bus_data   = (bus_req && beat_ok) ? mem_rdata : '0;
            rd_phase   = bus_req & ~beat_last;
         end
         default: ;
      endcase
      mem_rd_en = rd_phase & rd_ok;
      mem_addr  = rd_phase ? rd_off[MEM_AW-1:0] : '0;
      busy      = (state != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset)
         addr_reg <= '0;
      else if (state == ST_ADDR)
         addr_reg <= bus_addr - FB_BASE;
   end

   always_ff @(posedge clk) begin
      if (reset)
         range_err <= 1'b0;
      else if ((state == ST_BURST) && bus_req && !beat_ok)
         range_err <= 1'b1;
   end

endmodule

// File: tb/tb_fb_burst_responder.sv
// Directed and randomized bursts against a cycle-offset reference model of the responder.
module tb_fb_burst_responder;

   localparam int          WC   = 2;
   localparam int          BL   = 8;
   localparam int          NW   = 38400;
   localparam logic [31:0] BASE = 32'h0000_1050;

   logic        clk = 1'b0;
   logic        reset;
   logic        bus_req;
   logic [31:0] bus_addr;
   logic        bus_ack, bus_wait, bus_dvalid, mem_rd_en, busy, range_err;
   logic [15:0] bus_data, mem_addr, mem_rdata;

   logic [15:0] mem [NW];
   int          checks = 0;
   int          errors = 0;
   logic        rerr_exp = 1'b0;

   always #5 clk = ~clk;

   fb_burst_responder #(.WAIT_CYCLES(WC), .BURST_LEN(BL)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus_req    (bus_req),
      .bus_addr   (bus_addr),
      .bus_ack    (bus_ack),
      .bus_wait   (bus_wait),
      .bus_data   (bus_data),
      .bus_dvalid (bus_dvalid),
      .mem_rd_en  (mem_rd_en),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .busy       (busy),
      .range_err  (range_err)
   );

   // framebuffer memory, one-cycle read latency
   always @(posedge clk)
      if (mem_rd_en && mem_addr < NW) mem_rdata <= mem[mem_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic inr(input logic [31:0] off);
      return off < NW;
   endfunction

   function automatic logic [15:0] exp_word(input logic [31:0] off);
      return inr(off) ? mem[off[15:0]] : 16'h0;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         bus_req = 1'b0;
         @(negedge clk);
         chk("idle_ack", bus_ack, 0);
         chk("idle_busy", busy, 0);
         chk("idle_wait", bus_wait, 0);
         chk("idle_dvalid", bus_dvalid, 0);
         chk("idle_rerr", range_err, rerr_exp);
      end
   endtask

   // Begins in the cycle after the previous one; bus_req is left high unless aborted.
   task automatic do_burst(input logic [31:0] addr, input int abort_at);
      logic [31:0] off0, off;
      off0 = addr - BASE;
      @(posedge clk); #1;
      bus_req = 1'b1; bus_addr = addr;
      @(negedge clk);
      chk("ack", bus_ack, 1);
      chk("start_busy", busy, 0);
      chk("start_rerr", range_err, rerr_exp);
      @(posedge clk); #1;
      @(negedge clk);
      chk("addr_wait", bus_wait, 1);
      chk("addr_busy", busy, 1);
      chk("addr_dvalid", bus_dvalid, 0);
      for (int w = 0; w <= WC; w++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("wait", bus_wait, (w < WC));
         chk("wait_rd", mem_rd_en, (w == WC) && inr(off0));
         if ((w == WC) && inr(off0)) chk("wait_maddr", mem_addr, off0[15:0]);
      end
      for (int i = 0; i < BL; i++) begin
         off = off0 + i;
         @(posedge clk); #1;
         if (i == abort_at) begin
            bus_req = 1'b0;
            @(negedge clk);
            chk("abort_dvalid", bus_dvalid, 0);
            chk("abort_data", bus_data, 0);
            chk("abort_rd", mem_rd_en, 0);
            break;
         end
         @(negedge clk);
         chk("beat_dvalid", bus_dvalid, 1);
         chk("beat_wait", bus_wait, 0);
         chk("beat_data", bus_data, exp_word(off));
         chk("beat_rd", mem_rd_en, (i < BL-1) && inr(off + 1));
         if ((i < BL-1) && inr(off + 1)) chk("beat_maddr", mem_addr, off[15:0] + 16'd1);
         if (!inr(off)) rerr_exp = 1'b1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < NW; k++) mem[k] = 16'(k + 'h100);
      reset = 1'b1; bus_req = 1'b1; bus_addr = BASE;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ack", bus_ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rd", mem_rd_en, 0);
      chk("rst_maddr", mem_addr, 0);
      chk("rst_data", bus_data, 0);
      chk("rst_rerr", range_err, 0);
      @(posedge clk); #1;
      reset = 1'b0; bus_req = 1'b0;
      idle(2);

      // single in-range burst
      do_burst(BASE, -1);
      idle(1);
      // burst crossing the top of the framebuffer
      do_burst(BASE + 32'd38396, -1);
      idle(2);

      // abort on beat 3, immediate re-request
      do_burst(BASE + 32'd100, 3);
      do_burst(BASE + 32'd200, -1);
      idle(1);

      // reset during WAIT with bus_req held high
      @(posedge clk); #1;
      bus_req = 1'b1; bus_addr = BASE + 32'd16;
      @(negedge clk);
      chk("r_ack", bus_ack, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      rerr_exp = 1'b0;
      chk("r_ack_in_reset", bus_ack, 0);
      chk("r_busy", busy, 0);
      chk("r_wait", bus_wait, 0);
      chk("r_dvalid", bus_dvalid, 0);
      chk("r_rd", mem_rd_en, 0);
      chk("r_maddr", mem_addr, 0);
      chk("r_rerr", range_err, 0);
      @(posedge clk); #1;
      reset = 1'b0; bus_req = 1'b0;
      idle(1);
      do_burst(BASE + 32'd16, -1);

      // back-to-back: second ack in the cycle after the last beat
      do_burst(BASE, -1);
      do_burst(BASE + 32'd8, -1);
      idle(1);

      for (int n = 0; n < 24; n++) begin
         logic [31:0] a;
         int          ab, sel;
         sel = $urandom_range(0, 5);
         if (sel == 0)      a = BASE - 32'($urandom_range(1, 40));
         else if (sel == 1) a = BASE + 32'(NW - $urandom_range(1, 12));
         else               a = BASE + 32'($urandom_range(0, NW - BL));
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, BL - 1) : -1;
         do_burst(a, ab);
         idle($urandom_range(0, 2));
      end
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
